// File: rtl/exu_oitf_pkg.sv
// -----------------------------------------------------------------------------
// exu_oitf_pkg
//   Shared widths for the Outstanding Instruction Track FIFO.
//   RFIDX_WIDTH : register-file index width
//   OITF_DEPTH  : default number of tracked entries (power of 2, >= 2)
//   ITAG_WIDTH  : tag width, log2(OITF_DEPTH)
// -----------------------------------------------------------------------------
package exu_oitf_pkg;
    localparam int RFIDX_WIDTH = 5;
    localparam int OITF_DEPTH  = 2;
    localparam int ITAG_WIDTH  = $clog2(OITF_DEPTH);
endpackage

// File: rtl/exu_oitf_if.sv
// -----------------------------------------------------------------------------
// exu_oitf_if
//   Dispatch / writeback bundle between the EXU and the OITF.
//   master : dispatch + long-pipe commit side (drives enables and indices)
//   slave  : the OITF (drives ready, tags, hazard matches, retire view)
// -----------------------------------------------------------------------------
interface exu_oitf_if #(
    parameter int DEPTH = exu_oitf_pkg::OITF_DEPTH
);
    import exu_oitf_pkg::*;
    localparam int IW = $clog2(DEPTH);

    // dispatch side
    logic                   disp_oitf_ena;
    logic                   disp_oitf_ready;
    logic [IW-1:0]          disp_oitf_ptr;
    logic                   disp_oitf_rs1en;
    logic                   disp_oitf_rs2en;
    logic                   disp_oitf_rdwen;
    logic [RFIDX_WIDTH-1:0] disp_oitf_rs1idx;
    logic [RFIDX_WIDTH-1:0] disp_oitf_rs2idx;
    logic [RFIDX_WIDTH-1:0] disp_oitf_rdidx;
    logic                   oitfrd_match_disprs1;
    logic                   oitfrd_match_disprs2;
    logic                   oitfrd_match_disprd;
    // retire side
    logic                   oitf_ret_ena;
    logic [IW-1:0]          oitf_ret_ptr;
    logic [RFIDX_WIDTH-1:0] oitf_ret_rdidx;
    logic                   oitf_ret_rdwen;
    logic                   oitf_empty;

    modport master (
        output disp_oitf_ena, disp_oitf_rs1en, disp_oitf_rs2en, disp_oitf_rdwen,
               disp_oitf_rs1idx, disp_oitf_rs2idx, disp_oitf_rdidx, oitf_ret_ena,
        input  disp_oitf_ready, disp_oitf_ptr, oitfrd_match_disprs1,
               oitfrd_match_disprs2, oitfrd_match_disprd, oitf_ret_ptr,
               oitf_ret_rdidx, oitf_ret_rdwen, oitf_empty
    );

    modport slave (
        input  disp_oitf_ena, disp_oitf_rs1en, disp_oitf_rs2en, disp_oitf_rdwen,
               disp_oitf_rs1idx, disp_oitf_rs2idx, disp_oitf_rdidx, oitf_ret_ena,
        output disp_oitf_ready, disp_oitf_ptr, oitfrd_match_disprs1,
               oitfrd_match_disprs2, oitfrd_match_disprd, oitf_ret_ptr,
               oitf_ret_rdidx, oitf_ret_rdwen, oitf_empty
    );
endinterface

// File: rtl/exu_oitf_ptr.sv
// -----------------------------------------------------------------------------
// exu_oitf_ptr
//   Circular pointer with wrap flag.
//   clk, rst : clock, synchronous active-high reset
//   inc_i    : advance pointer by one
//   ptr_o    : index bits
//   flag_o   : wrap flag, toggles each time the index wraps DEPTH-1 -> 0
// -----------------------------------------------------------------------------
module exu_oitf_ptr #(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     inc_i,
    output logic [$clog2(DEPTH)-1:0] ptr_o,
    output logic                     flag_o
);
    localparam int AW = $clog2(DEPTH);

    // DEPTH is a power of 2, so the flag is simply the counter's carry bit.
    logic [AW:0] cnt_q, cnt_d;

    assign cnt_d = inc_i ? cnt_q + (AW+1)'(1) : cnt_q;

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign ptr_o  = cnt_q[AW-1:0];
    assign flag_o = cnt_q[AW];
endmodule

// File: rtl/exu_oitf.sv
// -----------------------------------------------------------------------------
// exu_oitf
//   Outstanding Instruction Track FIFO: records long-pipe instructions from
//   dispatch until their writeback commits, in order.
//   clk, rst : clock, synchronous active-high reset
//   oitf     : exu_oitf_if.slave -- allocation handshake + tag, RAW/WAW
//              hazard matches, oldest-entry retire view, empty flag
//   Optional: define OITF_RET_BYPASS_EN to let dispatch allocate into the
//   slot being retired in the same cycle (ready = ~full | ret_ena) and to
//   drop the retiring entry from hazard matches.
// -----------------------------------------------------------------------------
module exu_oitf
    import exu_oitf_pkg::*;
#(
    parameter int DEPTH = OITF_DEPTH
) (
    input  logic       clk,
    input  logic       rst,
    exu_oitf_if.slave  oitf
);
    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] wptr, rptr;
    logic          wflag, rflag;
    logic          empty, full, alloc, ret_fire;

    logic [DEPTH-1:0]                  vld_q, vld_d;
    logic [DEPTH-1:0]                  rdwen_q;
    logic [DEPTH-1:0][RFIDX_WIDTH-1:0] rdidx_q;

    logic [DEPTH-1:0] hit_rs1, hit_rs2, hit_rd;

    assign empty = (wptr == rptr) & (wflag == rflag);
    assign full  = (wptr == rptr) & (wflag != rflag);

`ifdef OITF_RET_BYPASS_EN
    assign oitf.disp_oitf_ready = ~full | oitf.oitf_ret_ena;
`else
    assign oitf.disp_oitf_ready = ~full;
`endif

    assign alloc    = oitf.disp_oitf_ena & oitf.disp_oitf_ready;
    // Retire on an empty FIFO is illegal upstream; drop it here.
    assign ret_fire = oitf.oitf_ret_ena & ~empty;

    exu_oitf_ptr #(.DEPTH(DEPTH)) u_wptr (
        .clk    (clk),
        .rst    (rst),
        .inc_i  (alloc),
        .ptr_o  (wptr),
        .flag_o (wflag)
    );

    exu_oitf_ptr #(.DEPTH(DEPTH)) u_rptr (
        .clk    (clk),
        .rst    (rst),
        .inc_i  (ret_fire),
        .ptr_o  (rptr),
        .flag_o (rflag)
    );

    // Clear before set: with bypass on a full FIFO wptr == rptr, and the
    // freshly allocated entry must survive.
    always_comb begin
        vld_d = vld_q;
        if (ret_fire) vld_d[rptr] = 1'b0;
        if (alloc)    vld_d[wptr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) vld_q <= '0;
        else     vld_q <= vld_d;
    end

    // Payload is only meaningful while vld is set, so it carries no reset.
    always_ff @(posedge clk) begin
        if (alloc) begin
            rdwen_q[wptr] <= oitf.disp_oitf_rdwen;
            rdidx_q[wptr] <= oitf.disp_oitf_rdidx;
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        logic live;
`ifdef OITF_RET_BYPASS_EN
        assign live = vld_q[i] & rdwen_q[i] & ~(oitf.oitf_ret_ena & (rptr == AW'(i)));
`else
        assign live = vld_q[i] & rdwen_q[i];
`endif
        // x0 is hardwired to zero and never carries a dependency.
        assign hit_rs1[i] = live & oitf.disp_oitf_rs1en & (oitf.disp_oitf_rs1idx != '0)
                          & (rdidx_q[i] == oitf.disp_oitf_rs1idx);
        assign hit_rs2[i] = live & oitf.disp_oitf_rs2en & (oitf.disp_oitf_rs2idx != '0)
                          & (rdidx_q[i] == oitf.disp_oitf_rs2idx);
        assign hit_rd[i]  = live & oitf.disp_oitf_rdwen & (oitf.disp_oitf_rdidx != '0)
                          & (rdidx_q[i] == oitf.disp_oitf_rdidx);
    end

    assign oitf.oitfrd_match_disprs1 = |hit_rs1;
    assign oitf.oitfrd_match_disprs2 = |hit_rs2;
    assign oitf.oitfrd_match_disprd  = |hit_rd;

    assign oitf.disp_oitf_ptr  = wptr;
    assign oitf.oitf_ret_ptr   = rptr;
    assign oitf.oitf_ret_rdidx = rdidx_q[rptr];
    assign oitf.oitf_ret_rdwen = rdwen_q[rptr];
    assign oitf.oitf_empty     = empty;
endmodule

// File: tb/tb_exu_oitf.sv
// -----------------------------------------------------------------------------
// tb_exu_oitf
//   Directed bench for exu_oitf with DEPTH=2. Table of per-cycle vectors
//   followed by hand sequences for reset-mid-flight, in-order retire, retire
//   on empty, and retire/match interaction. Expected values follow the
//   OITF_RET_BYPASS_EN setting of the build.
// -----------------------------------------------------------------------------
module tb_exu_oitf;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

`ifdef OITF_RET_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    exu_oitf_if #(.DEPTH(2)) bus ();
    exu_oitf #(.DEPTH(2)) dut (.clk(clk), .rst(rst), .oitf(bus));

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic       ena, wen;
        logic [4:0] rd;
        logic       e1;
        logic [4:0] i1;
        logic       e2;
        logic [4:0] i2;
        logic       ret;
        // expected
        logic       rdy, wp, rp, emp, m1, m2, md;
        logic       cr;      // retire view holds a valid entry -> check it
        logic [4:0] rrd;
        logic       rwen;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drv(input logic ena, input logic wen, input logic [4:0] rd,
                       input logic e1, input logic [4:0] i1,
                       input logic e2, input logic [4:0] i2, input logic ret);
        bus.disp_oitf_ena    = ena;
        bus.disp_oitf_rdwen  = wen;
        bus.disp_oitf_rdidx  = rd;
        bus.disp_oitf_rs1en  = e1;
        bus.disp_oitf_rs1idx = i1;
        bus.disp_oitf_rs2en  = e2;
        bus.disp_oitf_rs2idx = i2;
        bus.oitf_ret_ena     = ret;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //            ena wen rd e1 i1 e2 i2 ret | rdy  wp  rp  emp m1  m2 md | cr rrd rwen
        tbl[0] = '{0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 1, 0, 0, 0,   0, 0, 0};
        tbl[1] = '{1, 1, 5, 1, 5, 0, 0, 0,   1, 0, 0, 1, 0, 0, 0,   0, 0, 0};
        tbl[2] = '{0, 1, 5, 1, 5, 1, 6, 0,   1, 1, 0, 0, 1, 0, 1,   1, 5, 1};
        tbl[3] = '{1, 1, 0, 1, 0, 0, 0, 0,   1, 1, 0, 0, 0, 0, 0,   1, 5, 1};
        tbl[4] = '{0, 1, 0, 1, 0, 1, 5, 0,   0, 0, 0, 0, 0, 1, 0,   1, 5, 1};
        tbl[5] = '{0, 0, 0, 0, 0, 0, 0, 1, BYP, 0, 0, 0, 0, 0, 0,   1, 5, 1};
        tbl[6] = '{0, 0, 0, 0, 0, 1, 5, 0,   1, 0, 1, 0, 0, 0, 0,   1, 0, 1};
        tbl[7] = '{1, 1, 3, 0, 0, 0, 0, 0,   1, 0, 1, 0, 0, 0, 0,   1, 0, 1};
        tbl[8] = '{1, 1, 9, 1, 3, 0, 0, 1, BYP, 1, 1, 0, 1, 0, 0,   1, 0, 1};
        tbl[9] = '{0, 0, 0, 1, 9, 1, 3, 0, !BYP, !BYP, 0, 0, BYP, 1, 0, 1, 3, 1};

        // ---- reset state (entries cleared, so no match even with enables) --
        rst = 1'b1;
        drv(0, 1, 5, 1, 5, 1, 5, 0);
        repeat (2) @(posedge clk);
        #4;
        chk("reset.empty", bus.oitf_empty, 1);
        chk("reset.ready", bus.disp_oitf_ready, 1);
        chk("reset.disp_ptr", bus.disp_oitf_ptr, 0);
        chk("reset.ret_ptr", bus.oitf_ret_ptr, 0);
        chk("reset.m1", bus.oitfrd_match_disprs1, 0);
        chk("reset.m2", bus.oitfrd_match_disprs2, 0);
        chk("reset.md", bus.oitfrd_match_disprd, 0);
        rst = 1'b0;
        cyc();

        // ---- table vectors: outputs checked before the edge that commits ---
        for (int i = 0; i < 10; i++) begin
            drv(tbl[i].ena, tbl[i].wen, tbl[i].rd, tbl[i].e1, tbl[i].i1,
                tbl[i].e2, tbl[i].i2, tbl[i].ret);
            #3;
            chk($sformatf("T%0d.ready", i), bus.disp_oitf_ready, tbl[i].rdy);
            chk($sformatf("T%0d.disp_ptr", i), bus.disp_oitf_ptr, tbl[i].wp);
            chk($sformatf("T%0d.ret_ptr", i), bus.oitf_ret_ptr, tbl[i].rp);
            chk($sformatf("T%0d.empty", i), bus.oitf_empty, tbl[i].emp);
            chk($sformatf("T%0d.m1", i), bus.oitfrd_match_disprs1, tbl[i].m1);
            chk($sformatf("T%0d.m2", i), bus.oitfrd_match_disprs2, tbl[i].m2);
            chk($sformatf("T%0d.md", i), bus.oitfrd_match_disprd, tbl[i].md);
            if (tbl[i].cr) begin
                chk($sformatf("T%0d.ret_rdidx", i), bus.oitf_ret_rdidx, tbl[i].rrd);
                chk($sformatf("T%0d.ret_rdwen", i), bus.oitf_ret_rdwen, tbl[i].rwen);
            end
            cyc();
        end

        // ---- reset with two entries outstanding ----------------------------
        drv(1, 1, 4, 0, 0, 0, 0, 0);   // fills the FIFO (already full with bypass)
        cyc();
        drv(0, 0, 0, 1, 3, 0, 0, 0);
        rst = 1'b1;
        #3;
        chk("rstmid.pre_m1", bus.oitfrd_match_disprs1, 1);
        chk("rstmid.pre_ready", bus.disp_oitf_ready, 0);
        cyc();
        #3;
        chk("rstmid.empty", bus.oitf_empty, 1);
        chk("rstmid.ready", bus.disp_oitf_ready, 1);
        chk("rstmid.disp_ptr", bus.disp_oitf_ptr, 0);
        chk("rstmid.ret_ptr", bus.oitf_ret_ptr, 0);
        chk("rstmid.m1", bus.oitfrd_match_disprs1, 0);
        rst = 1'b0;
        cyc();

        // ---- in-order retire: rd=3 (wen) then rd=7 (no wen) ----------------
        drv(1, 1, 3, 0, 0, 0, 0, 0);
        cyc();
        drv(1, 0, 7, 0, 0, 0, 0, 0);
        cyc();
        drv(0, 0, 0, 1, 7, 0, 0, 0);
        #3;
        chk("seq.full_ready", bus.disp_oitf_ready, 0);
        chk("seq.full_disp_ptr", bus.disp_oitf_ptr, 0);
        chk("seq.full_empty", bus.oitf_empty, 0);
        chk("seq.first_rdidx", bus.oitf_ret_rdidx, 3);
        chk("seq.first_rdwen", bus.oitf_ret_rdwen, 1);
        chk("seq.nowen_m1", bus.oitfrd_match_disprs1, 0);
        cyc();
        drv(0, 0, 0, 0, 0, 0, 0, 1);
        cyc();
        drv(0, 0, 0, 0, 0, 0, 0, 1);
        #3;
        chk("seq.second_rdidx", bus.oitf_ret_rdidx, 7);
        chk("seq.second_rdwen", bus.oitf_ret_rdwen, 0);
        chk("seq.second_ret_ptr", bus.oitf_ret_ptr, 1);
        chk("seq.second_ready", bus.disp_oitf_ready, 1);
        cyc();
        // FIFO is now empty; the retire below is an illegal request
        drv(0, 0, 0, 0, 0, 0, 0, 1);
        #3;
        chk("seq.drained_empty", bus.oitf_empty, 1);
        chk("seq.drained_ret_ptr", bus.oitf_ret_ptr, 0);
        $display("note: illegal oitf_ret_ena while empty driven on purpose");
        cyc();
        drv(0, 0, 0, 0, 0, 0, 0, 0);
        #3;
        chk("emptyret.ret_ptr", bus.oitf_ret_ptr, 0);
        chk("emptyret.disp_ptr", bus.disp_oitf_ptr, 0);
        chk("emptyret.empty", bus.oitf_empty, 1);
        chk("emptyret.ready", bus.disp_oitf_ready, 1);
        cyc();

        // ---- match on the entry being retired this cycle -------------------
        drv(1, 1, 8, 0, 0, 0, 0, 0);
        cyc();
        drv(0, 0, 0, 1, 8, 0, 0, 1);
        #3;
        chk("retmatch.m1", bus.oitfrd_match_disprs1, !BYP);
        chk("retmatch.ret_rdidx", bus.oitf_ret_rdidx, 8);
        cyc();
        drv(0, 0, 0, 0, 0, 0, 0, 0);
        #3;
        chk("retmatch.empty", bus.oitf_empty, 1);
        chk("retmatch.ret_ptr", bus.oitf_ret_ptr, 1);
        chk("retmatch.disp_ptr", bus.disp_oitf_ptr, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
